seven_seg_scan_n: RTL and testbench

Parametrised multiplexed seven-segment driver for the FPGA reaction game, replacing the fixed 4-digit display. It drives `DIGITS` common-anode digits from either a binary value or caller-supplied segment patterns. Binary values are converted to BCD by a sequential double-dabble engine with a load/busy handshake rather than by dividers. It adds leading-zero blanking, per-digit decimal points, overflow dashes and an optional blink. It sits between the game FSM and the board's `seg`/`an` pins.

---
 rtl/seven_seg_scan_n.sv | 156 +++++++++++++++
 tb/tb_seven_seg_scan_n.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_n.sv
// seven_seg_scan_n: multiplexed seven-segment driver with sequential double-dabble BCD conversion
// Ports: clk_500Hz/rst (sync, active-high); value/load/busy conversion handshake;
// select/text/lz_blank/dp/blink display controls; seg/dp_n/an active-low board pins.
// Macro SEVEN_SEG_BLINK_EN: when defined, blink darkens all anodes during the off phase.
module seven_seg_scan_n #(
  parameter int DIGITS    = 4,
  parameter int WIDTH     = 14,
  parameter int BLINK_DIV = 50
) (
  input  logic                clk_500Hz,
  input  logic                rst,
  input  logic [WIDTH-1:0]    value,
  input  logic                load,
  output logic                busy,
  input  logic                select,
  input  logic [7*DIGITS-1:0] text,
  input  logic                lz_blank,
  input  logic [DIGITS-1:0]   dp,
  input  logic                blink,
  output logic [6:0]          seg,
  output logic                dp_n,
  output logic [DIGITS-1:0]   an
);
  localparam int KW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [63:0] MAX_V = 64'(10 ** DIGITS - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0] bcd_q, bcd_d, dig_q, dig_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, ovf_q, ovf_d, busy_q, busy_d, dp_n_q, dp_n_d, zs;
  logic [KW-1:0] k_q, k_d;
  logic [6:0] seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d, lead;
  logic [3:0] nib;
`ifdef SEVEN_SEG_BLINK_EN
  localparam int BCW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [BCW-1:0] bc_q, bc_d;
  logic on_q, on_d;
  logic wrap;
`else
  logic unused_blink;
  assign unused_blink = blink;
`endif
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0011000;
      default: dec = 7'b1111111;
    endcase
  endfunction
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    dig_d = dig_q;
    ovf_d = ovf_q;
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = adj[4*i +: 4] >= 4'd5 ? adj[4*i +: 4] + 4'd3 : adj[4*i +: 4];
    case (state_q)
      IDLE: if (load) begin
        state_d = SHIFT;
        sh_d = value;
        bcd_d = '0;
        cnt_d = '0;
        pend_d = 64'(value) > MAX_V;
      end
      // Truncating the BCD to 4*DIGITS bits keeps the low digits exact: adjustments only carry upward.
      SHIFT: begin
        bcd_d = {adj[BW-2:0], sh_q[WIDTH-1]};
        sh_d = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH - 1) ? COMMIT : SHIFT;
      end
      COMMIT: begin
        dig_d = bcd_q;
        ovf_d = pend_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_q != IDLE;
    k_d = k_q == KW'(DIGITS - 1) ? '0 : k_q + 1'b1;
    zs = 1'b1;
    lead = '0;
    for (int i = 0; i < DIGITS; i++) begin
      zs = zs & (dig_q[4*(DIGITS-1-i) +: 4] == 4'd0);
      lead[i] = zs & (i != DIGITS - 1);
    end
    nib = dig_q[4*(DIGITS-1-int'(k_q)) +: 4];
    seg_d = !select ? ~text[7*k_q +: 7] : ovf_q ? 7'b0111111 : (lz_blank && lead[k_q]) ? 7'h7F : dec(nib);
    dp_n_d = ~dp[k_q];
`ifdef SEVEN_SEG_BLINK_EN
    wrap = bc_q == BCW'(BLINK_DIV - 1);
    bc_d = (!blink || wrap) ? '0 : bc_q + 1'b1;
    on_d = !blink ? 1'b1 : wrap ? ~on_q : on_q;
    an_d = (blink && !on_q) ? '1 : ~(DIGITS'(1) << k_q);
`else
    an_d = ~(DIGITS'(1) << k_q);
`endif
  end
  always_ff @(posedge clk_500Hz) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      dig_q <= '0;
      ovf_q <= 1'b0;
      busy_q <= 1'b0;
      k_q <= '0;
      seg_q <= 7'h7F;
      dp_n_q <= 1'b1;
      an_q <= '1;
`ifdef SEVEN_SEG_BLINK_EN
      bc_q <= '0;
      on_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      dig_q <= dig_d;
      ovf_q <= ovf_d;
      busy_q <= busy_d;
      k_q <= k_d;
      seg_q <= seg_d;
      dp_n_q <= dp_n_d;
      an_q <= an_d;
`ifdef SEVEN_SEG_BLINK_EN
      bc_q <= bc_d;
      on_q <= on_d;
`endif
    end
  end
  assign busy = busy_q;
  assign seg = seg_q;
  assign dp_n = dp_n_q;
  assign an = an_q;
endmodule

// File: tb/tb_seven_seg_scan_n.sv
// tb_seven_seg_scan_n: directed and randomized checks of seven_seg_scan_n against a decimal-arithmetic model
module tb_seven_seg_scan_n;
  localparam int DIGITS = 4;
  localparam int WIDTH = 14;
  localparam int BLINK_DIV = 50;
  logic clk_500Hz = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic select = 1'b0;
  logic lz_blank = 1'b0;
  logic blink = 1'b0;
  logic [WIDTH-1:0] value = '0;
  logic [7*DIGITS-1:0] text = '0;
  logic [DIGITS-1:0] dp = '0;
  logic busy, dp_n;
  logic [6:0] seg;
  logic [DIGITS-1:0] an;
  int checks = 0;
  int errors = 0;
  int mk = 0;
  int m_val = 0;
  bit m_ovf = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
  int bc = 0;
  bit mon = 1'b1;
`endif
  logic [6:0] pat [10];
  always #5 clk_500Hz = ~clk_500Hz;
  seven_seg_scan_n #(.DIGITS(DIGITS), .WIDTH(WIDTH), .BLINK_DIV(BLINK_DIV)) dut (
    .clk_500Hz(clk_500Hz), .rst(rst), .value(value), .load(load), .busy(busy),
    .select(select), .text(text), .lz_blank(lz_blank), .dp(dp), .blink(blink),
    .seg(seg), .dp_n(dp_n), .an(an)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  function automatic logic [6:0] exp_seg(input int idx);
    int p;
    p = 1;
    for (int i = 0; i < DIGITS - 1 - idx; i++) p = p * 10;
    if (!select) return ~text[7*idx +: 7];
    if (m_ovf) return 7'b0111111;
    if (lz_blank && idx != DIGITS - 1 && m_val < p) return 7'h7F;
    return pat[(m_val / p) % 10];
  endfunction
  task automatic tick(input string tag);
    int idx;
    logic [6:0] es;
    logic [DIGITS-1:0] ea;
    logic ed;
    idx = mk;
    es = exp_seg(idx);
    ea = ~(DIGITS'(1) << idx);
    ed = ~dp[idx];
`ifdef SEVEN_SEG_BLINK_EN
    if (blink && !mon) ea = '1;
    if (!blink) begin bc = 0; mon = 1'b1; end
    else if (bc == BLINK_DIV - 1) begin bc = 0; mon = !mon; end
    else bc++;
`endif
    @(posedge clk_500Hz); #1;
    mk = (mk + 1) % DIGITS;
    chk({tag, "/an"}, 32'(an), 32'(ea));
    chk({tag, "/seg"}, 32'(seg), 32'(es));
    chk({tag, "/dp_n"}, 32'(dp_n), 32'(ed));
  endtask
  task automatic ticks(input string tag, input int n);
    repeat (n) tick(tag);
  endtask
  task automatic rst_cycles(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk_500Hz); #1;
      chk("rst/an", 32'(an), 32'hF);
      chk("rst/seg", 32'(seg), 32'h7F);
      chk("rst/dp_n", 32'(dp_n), 32'h1);
      chk("rst/busy", 32'(busy), 32'h0);
    end
    rst = 1'b0;
    mk = 0;
    m_val = 0;
    m_ovf = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
    bc = 0;
    mon = 1'b1;
`endif
  endtask
  task automatic start(input int v);
    value = WIDTH'(v);
    load = 1'b1;
    tick("load");
    load = 1'b0;
  endtask
  task automatic wait_conv(input int v, input int at, input int v2);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      load = (n == at);
      value = load ? WIDTH'(v2) : WIDTH'($urandom);
      tick("conv");
      if (busy === 1'b1) begin
        n++;
        if (n == WIDTH + 1) begin
          m_val = v;
          m_ovf = v > 9999;
        end
      end else done = 1'b1;
    end
    load = 1'b0;
    chk("busy_cycles", 32'(n), 32'(WIDTH + 1));
  endtask
  task automatic convert(input int v);
    start(v);
    wait_conv(v, -1, 0);
  endtask
  initial begin
    int v;
    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
    select = 1'b1;
    rst_cycles(3);
    ticks("zero", 8);
    convert(1234);
    ticks("n1234", 8);
    lz_blank = 1'b1;
    convert(7);
    ticks("lz7", 4);
    lz_blank = 1'b0;
    ticks("n0007", 4);
    convert(0);
    lz_blank = 1'b1;
    ticks("lz0", 4);
    lz_blank = 1'b0;
    start(12000);
    wait_conv(12000, 5, 5);
    ticks("ovf", 4);
    lz_blank = 1'b1;
    ticks("ovf_lz", 4);
    lz_blank = 1'b0;
    convert(9999);
    ticks("n9999", 4);
    convert(10000);
    ticks("n10000", 4);
    start(42);
    wait_conv(42, WIDTH + 1, 9876);
    wait_conv(9876, -1, 0);
    ticks("chain", 4);
    select = 1'b0;
    text = {7'h6E, 7'h6D, 7'h77, 7'h79};
    dp = 4'b1000;
    ticks("easy", 8);
    for (int r = 0; r < 10; r++) begin
      select = 1'b1;
      lz_blank = 1'($urandom);
      dp = DIGITS'($urandom);
      v = int'($urandom_range(0, 16383));
      convert(v);
      for (int j = 0; j < 8; j++) begin
        select = 1'($urandom_range(0, 3) != 0);
        lz_blank = 1'($urandom);
        dp = DIGITS'($urandom);
        text = (7*DIGITS)'({$urandom, $urandom});
        blink = 1'($urandom);
        tick("rand");
      end
    end
    blink = 1'b0;
    select = 1'b1;
    lz_blank = 1'b0;
    start(5555);
    ticks("abort", 4);
    rst_cycles(2);
    ticks("post_abort", 8);
    convert(321);
    blink = 1'b1;
    ticks("blink", 120);
    blink = 1'b0;
    ticks("unblink", 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
